// File: rtl/rambus_pkg.sv
// Shared types and address widths for the RAM sample fetcher.
package rambus_pkg;
  localparam int WORD_ADR_W = 8;
  localparam int BYTE_ADR_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT_SPACE = 2'd2,
    ST_FINISH     = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with synchronous flush.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head word is presented combinationally; zero while empty.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/rambus_sample_fetcher.sv
// Wishbone master that streams a block of RAM words into a FWFT sample buffer.
module rambus_sample_fetcher
  import rambus_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [WORD_ADR_W-1:0] base_word,
  input  logic [7:0]            length,
  output logic                  rambus_wb_clk_o,
  output logic                  rambus_wb_rst_o,
  output logic                  rambus_wb_stb_o,
  output logic                  rambus_wb_cyc_o,
  output logic                  rambus_wb_we_o,
  output logic [3:0]            rambus_wb_sel_o,
  output logic [31:0]           rambus_wb_dat_o,
  output logic [BYTE_ADR_W-1:0] rambus_wb_adr_o,
  input  logic                  rambus_wb_ack_i,
  input  logic [31:0]           rambus_wb_dat_i,
  output logic [31:0]           sample_data,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_t          state;
  logic                  req;
  logic [WORD_ADR_W-1:0] word_ptr, base_r, ptr_next;
  logic [7:0]            len_r, idx, tcnt;
  logic                  loop_r, stop_pend;
  logic                  fifo_full, fifo_empty, pop, push, flush;
  logic                  acked, stopping, last, room_after_push;
  logic [CW-1:0]         fifo_count;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = wb_rst_i;
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = 4'hF;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_cyc_o = req;
  assign rambus_wb_stb_o = req;

  assign sample_valid = !fifo_empty;
  assign pop          = sample_valid && sample_ready;
  assign stopping     = stop || stop_pend;
  assign acked        = (state == ST_REQ) && rambus_wb_ack_i;
  // A word acked after a stop request is dropped and the buffer is cleared.
  assign push         = acked && !stopping;
  assign flush        = ((state != ST_REQ) && stop) || (acked && stopping);
  assign last         = (idx == len_r);
  assign ptr_next     = (last && loop_r) ? base_r : word_ptr + 8'd1;
  assign room_after_push = (int'(fifo_count) + 1 - int'(pop)) < FIFO_DEPTH;

  sample_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (rambus_wb_dat_i),
    .rdata (sample_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;  req <= 1'b0;  rambus_wb_adr_o <= '0;
      word_ptr <= '0;  base_r <= '0;  len_r <= '0;  idx <= '0;
      loop_r <= 1'b0;  tcnt <= '0;  stop_pend <= 1'b0;
      busy <= 1'b0;  done <= 1'b0;  err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop && start) begin
            base_r <= base_word;  len_r <= length;  loop_r <= loop_en;
            word_ptr <= base_word;  idx <= '0;  tcnt <= '0;
            stop_pend <= 1'b0;  err <= 1'b0;  busy <= 1'b1;
            if (!fifo_full) begin
              state <= ST_REQ;
              req <= 1'b1;
              rambus_wb_adr_o <= {base_word, 2'b00};
            end else begin
              state <= ST_WAIT_SPACE;
            end
          end
        end
        ST_REQ: begin
          if (rambus_wb_ack_i) begin
            tcnt <= '0;
            if (stopping) begin
              state <= ST_IDLE;  req <= 1'b0;  busy <= 1'b0;  stop_pend <= 1'b0;
            end else begin
              word_ptr <= ptr_next;
              idx <= (last && loop_r) ? 8'd0 : idx + 8'd1;
              if (last && !loop_r) begin
                state <= ST_FINISH;  req <= 1'b0;  done <= 1'b1;
              end else if (room_after_push) begin
                rambus_wb_adr_o <= {ptr_next, 2'b00};
              end else begin
                state <= ST_WAIT_SPACE;  req <= 1'b0;
              end
            end
          end else if (tcnt == TO_LAST) begin
            state <= ST_IDLE;  req <= 1'b0;  busy <= 1'b0;
            err <= 1'b1;  tcnt <= '0;  stop_pend <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
            if (stop) stop_pend <= 1'b1;
          end
        end
        ST_WAIT_SPACE: begin
          if (stop) begin
            state <= ST_IDLE;  busy <= 1'b0;
          end else if (!fifo_full) begin
            state <= ST_REQ;  req <= 1'b1;
            rambus_wb_adr_o <= {word_ptr, 2'b00};
          end
        end
        default: begin
          state <= ST_IDLE;  busy <= 1'b0;  done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rambus_sample_fetcher.sv
// Directed bench for rambus_sample_fetcher with a latency-configurable RAM model.
module tb_rambus_sample_fetcher;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, sample_ready = 1'b1;
  logic [7:0]  base_word = '0, length = '0;
  logic        wb_clk, wb_rst, stb, cyc, we, ack, sample_valid, busy, done, err;
  logic [3:0]  sel;
  logic [31:0] dat_o, dat_i, sample_data;
  logic [9:0]  adr;

  int          pass_cnt = 0, total_cnt = 0;
  int          ack_lat = 0, lat_cnt = 0, done_cnt = 0, cyc_cnt = 0;
  logic        ack_en = 1'b1;
  logic [9:0]  ack_q[$];
  logic [31:0] smp_q[$];

  always #5 clk = ~clk;

  rambus_sample_fetcher #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .stop(stop), .loop_en(loop_en),
    .base_word(base_word), .length(length),
    .rambus_wb_clk_o(wb_clk), .rambus_wb_rst_o(wb_rst), .rambus_wb_stb_o(stb),
    .rambus_wb_cyc_o(cyc), .rambus_wb_we_o(we), .rambus_wb_sel_o(sel),
    .rambus_wb_dat_o(dat_o), .rambus_wb_adr_o(adr), .rambus_wb_ack_i(ack),
    .rambus_wb_dat_i(dat_i), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .busy(busy), .done(done), .err(err)
  );

  // RAM model: word data is 0xA5000000 | byte address, ack after ack_lat idle cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0;  lat_cnt <= 0;  dat_i <= '0;
    end else if (cyc && stb && !ack && ack_en) begin
      if (lat_cnt == ack_lat) begin
        ack <= 1'b1;  lat_cnt <= 0;  dat_i <= 32'hA500_0000 | {22'h0, adr};
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else begin
      ack <= 1'b0;  lat_cnt <= 0;
    end
  end

  always @(negedge clk) begin
    if (cyc && stb && ack) ack_q.push_back(adr);
    if (sample_valid && sample_ready) smp_q.push_back(sample_data);
    if (done) done_cnt++;
    if (cyc) cyc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic go(input logic [7:0] b, input logic [7:0] l, input logic lp);
    ack_q.delete();  smp_q.delete();  done_cnt = 0;  cyc_cnt = 0;
    @(posedge clk); #1;
    base_word = b;  length = l;  loop_en = lp;  start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < maxc);
    check(tag, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_acks(input string tag, input int cnt, input int maxc);
    int n = 0;
    while (ack_q.size() < cnt && n < maxc) begin @(negedge clk); n++; end
    check(tag, {31'h0, ack_q.size() >= cnt}, 32'h1);
  endtask

  initial begin
    logic [9:0] exp_adr[4];
    repeat (2) @(posedge clk);
    #1;
    // Reset values
    check("rst_cyc", {31'h0, cyc}, 32'h0);
    check("rst_adr", {22'h0, adr}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("tie_sel", {28'h0, sel}, 32'hF);
    check("tie_we", {31'h0, we}, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rel_no_bus", {31'h0, cyc}, 32'h0);

    // Basic 4-word block
    go(8'h10, 8'd3, 1'b0);
    @(negedge clk);
    check("t1_cyc_latency", {31'h0, cyc}, 32'h1);
    check("t1_first_adr", {22'h0, adr}, 32'h040);
    wait_idle("t1_idle", 50);
    repeat (2) @(negedge clk);
    check("t1_nacks", ack_q.size(), 4);
    check("t1_nsamples", smp_q.size(), 4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      check("t1_adr", {22'h0, ack_q[i]}, 32'h040 + 32'(4 * i));
    for (int i = 0; i < 4 && i < smp_q.size(); i++)
      check("t1_sample", smp_q[i], 32'hA500_0040 + 32'(4 * i));
    check("t1_done_once", done_cnt, 1);

    // Address wrap past word 255
    exp_adr = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    go(8'hFE, 8'd3, 1'b0);
    wait_idle("t2_idle", 50);
    check("t2_nacks", ack_q.size(), 4);
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      check("t2_adr", {22'h0, ack_q[i]}, {22'h0, exp_adr[i]});

    // Backpressure: buffer fills, fetcher parks with the bus idle
    sample_ready = 1'b0;
    go(8'h20, 8'd9, 1'b0);
    repeat (30) @(negedge clk);
    check("t3_acks_held", ack_q.size(), 4);
    check("t3_cyc_low", {31'h0, cyc}, 32'h0);
    check("t3_busy", {31'h0, busy}, 32'h1);
    check("t3_head", sample_data, 32'hA500_0080);
    @(posedge clk); #1;
    sample_ready = 1'b1;
    wait_idle("t3_idle", 100);
    repeat (2) @(negedge clk);
    check("t3_nsamples", smp_q.size(), 10);
    for (int i = 0; i < 10 && i < smp_q.size(); i++)
      check("t3_sample", smp_q[i], 32'hA500_0080 + 32'(4 * i));
    check("t3_done_once", done_cnt, 1);

    // Loop mode, then stop while a request is pending
    ack_lat = 3;
    go(8'h00, 8'd1, 1'b1);
    wait_acks("t4_acks", 5, 200);
    for (int i = 0; i < 5 && i < ack_q.size(); i++)
      check("t4_adr", {22'h0, ack_q[i]}, (i % 2 == 0) ? 32'h000 : 32'h004);
    begin
      int n = 0;
      while (!(cyc && !ack) && n < 20) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    begin
      int n = 0;
      while (!ack && n < 20) begin @(negedge clk); n++; end
      check("t4_ack_done", {31'h0, ack}, 32'h1);
    end
    @(negedge clk);
    @(negedge clk);
    check("t4_busy_off", {31'h0, busy}, 32'h0);
    check("t4_flushed", {31'h0, sample_valid}, 32'h0);
    check("t4_cyc_off", {31'h0, cyc}, 32'h0);
    check("t4_no_done", done_cnt, 0);

    // Timeout with no ack
    ack_lat = 0;
    ack_en = 1'b0;
    go(8'h30, 8'd0, 1'b0);
    wait_idle("t5_idle", 400);
    check("t5_cyc_cycles", cyc_cnt, 255);
    check("t5_err", {31'h0, err}, 32'h1);
    check("t5_cyc_low", {31'h0, cyc}, 32'h0);
    ack_en = 1'b1;
    go(8'h30, 8'd0, 1'b0);
    @(negedge clk);
    check("t5_err_clear", {31'h0, err}, 32'h0);
    wait_idle("t5_idle2", 50);
    check("t5_done", done_cnt, 1);

    // Asynchronous reset mid-request with two buffered words
    sample_ready = 1'b0;
    ack_lat = 10;
    go(8'h50, 8'd9, 1'b0);
    wait_acks("t6_acks", 2, 100);
    @(negedge clk);
    check("t6_pre_valid", {31'h0, sample_valid}, 32'h1);
    check("t6_pre_cyc", {31'h0, cyc}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t6_cyc", {31'h0, cyc}, 32'h0);
    check("t6_stb", {31'h0, stb}, 32'h0);
    check("t6_adr", {22'h0, adr}, 32'h0);
    check("t6_valid", {31'h0, sample_valid}, 32'h0);
    check("t6_data", sample_data, 32'h0);
    check("t6_busy", {31'h0, busy}, 32'h0);
    check("t6_done", {31'h0, done}, 32'h0);
    check("t6_err", {31'h0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    ack_q.delete();
    repeat (5) @(negedge clk);
    check("t6_quiet", {31'h0, cyc}, 32'h0);
    check("t6_no_acks", ack_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
